// File: rtl/hub_noc_pkg.sv
// Shared hub NoC definitions: flit type codes, hub port indices, arbiter FSM states.
package hub_noc_pkg;
  localparam int NUM_IN = 7;
  localparam int FLIT_W = 20;

  localparam logic [1:0] FLIT_SINGLE = 2'b11;
  localparam logic [1:0] FLIT_HEAD   = 2'b10;
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_TAIL   = 2'b01;

  localparam logic [2:0] P_RING_CW  = 3'd0;
  localparam logic [2:0] P_RING_CCW = 3'd1;
  localparam logic [2:0] P_SH       = 3'd2;
  localparam logic [2:0] P_LEAF0    = 3'd3;
  localparam logic [2:0] P_LEAF1    = 3'd4;
  localparam logic [2:0] P_LEAF2    = 3'd5;
  localparam logic [2:0] P_LEAF3    = 3'd6;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Advance a round-robin pointer past idx, wrapping hi -> lo.
  function automatic logic [2:0] ptr_next(input logic [2:0] idx, input logic [2:0] lo,
                                          input logic [2:0] hi);
    return (idx == hi) ? lo : idx + 3'd1;
  endfunction
endpackage

// File: rtl/rr_pick7.sv
// Combinational 7-way round-robin picker: first request at or after ptr, wrapping 6 -> 0.
module rr_pick7
  import hub_noc_pkg::*;
(
  input  logic [NUM_IN-1:0] req,
  input  logic [2:0]        ptr,
  output logic [NUM_IN-1:0] gnt,
  output logic [2:0]        idx,
  output logic              vld
);
  logic [3:0] j;

  // Scan farthest-first so the nearest requester overwrites the result.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + 4'(k);
      if (j >= 4'(NUM_IN)) j = j - 4'(NUM_IN);
      if (req[j[2:0]]) begin
        gnt = NUM_IN'(1) << j[2:0];
        idx = j[2:0];
        vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/hub_port_arbiter.sv
// Output-port scheduler: round-robin with wormhole locking and downstream credits.
// HUB_ARB_RING_PRIORITY_EN: ring inputs take priority over locals, with anti-starvation.
module hub_port_arbiter
  import hub_noc_pkg::*;
#(
  parameter int NUM_IN  = 7,
  parameter int FLIT_W  = 20,
  parameter int CREDITS = 4,
  parameter int CNT_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        req,
  input  logic [NUM_IN*FLIT_W-1:0] flit_in,
  output logic [NUM_IN-1:0]        grant,
  output logic [FLIT_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     credit_in,
  output logic [CNT_W-1:0]         credit_cnt,
  output logic                     err_credit_ovf
);
  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);

  arb_state_e          state_q, state_d;
  logic [2:0]          owner_q, owner_d;
  logic [CNT_W-1:0]    credit_q, credit_d;
  logic                ovf_q, ovf_d;
  logic [FLIT_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;

  logic                can_send, send, idle_grant, pick_vld;
  logic [NUM_IN-1:0]   pick_oh;
  logic [2:0]          pick_idx, win_idx;
  logic [FLIT_W-1:0]   win_flit;
  logic [1:0]          win_type;

  assign can_send   = (credit_q != '0);
  assign idle_grant = (state_q == ARB_IDLE) && can_send && pick_vld;
  assign win_idx    = (state_q == ARB_IDLE) ? pick_idx : owner_q;
  assign win_flit   = flit_in[int'(win_idx)*FLIT_W +: FLIT_W];
  assign win_type   = win_flit[FLIT_W-1 -: 2];

`ifdef HUB_ARB_RING_PRIORITY_EN
  logic [2:0]        ring_ptr_q, ring_ptr_d, loc_ptr_q, loc_ptr_d;
  logic [3:0]        starv_q, starv_d;
  logic [NUM_IN-1:0] ring_oh, loc_oh;
  logic [2:0]        ring_idx, loc_idx;
  logic              ring_vld, loc_vld, pick_local;

  rr_pick7 u_pick_ring (.req({5'b0, req[1:0]}), .ptr(ring_ptr_q),
                        .gnt(ring_oh), .idx(ring_idx), .vld(ring_vld));
  rr_pick7 u_pick_loc  (.req({req[6:2], 2'b0}), .ptr(loc_ptr_q),
                        .gnt(loc_oh), .idx(loc_idx), .vld(loc_vld));

  // A saturated starvation count hands one IDLE grant to the local class.
  always_comb begin
    pick_local = loc_vld && (!ring_vld || starv_q == 4'd15);
    pick_oh    = pick_local ? loc_oh : ring_oh;
    pick_idx   = pick_local ? loc_idx : ring_idx;
    pick_vld   = ring_vld || loc_vld;
    ring_ptr_d = ring_ptr_q;
    loc_ptr_d  = loc_ptr_q;
    starv_d    = starv_q;
    if (idle_grant) begin
      if (pick_local) begin
        loc_ptr_d = ptr_next(loc_idx, P_SH, P_LEAF3);
        starv_d   = 4'd0;
      end else begin
        ring_ptr_d = ptr_next(ring_idx, P_RING_CW, P_RING_CCW);
        if (loc_vld && starv_q != 4'd15) starv_d = starv_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ring_ptr_q <= P_RING_CW;
      loc_ptr_q  <= P_SH;
      starv_q    <= 4'd0;
    end else begin
      ring_ptr_q <= ring_ptr_d;
      loc_ptr_q  <= loc_ptr_d;
      starv_q    <= starv_d;
    end
  end
`else
  logic [2:0] rr_ptr_q, rr_ptr_d;

  rr_pick7 u_pick (.req(req), .ptr(rr_ptr_q), .gnt(pick_oh), .idx(pick_idx), .vld(pick_vld));

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (idle_grant) rr_ptr_d = ptr_next(pick_idx, P_RING_CW, P_LEAF3);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    grant       = '0;
    send        = 1'b0;
    credit_d    = credit_q;
    ovf_d       = ovf_q;
    case (state_q)
      ARB_IDLE: if (idle_grant) begin
        grant = pick_oh;
        send  = 1'b1;
        if (win_type == FLIT_HEAD) begin
          state_d = ARB_LOCKED;
          owner_d = pick_idx;
        end
      end
      ARB_LOCKED: if (can_send && req[owner_q]) begin
        grant[owner_q] = 1'b1;
        send           = 1'b1;
        // A stray single inside a packet also releases the lock.
        if (win_type == FLIT_TAIL || win_type == FLIT_SINGLE) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    if (send && !credit_in) begin
      credit_d = credit_q - CNT_W'(1);
    end else if (!send && credit_in) begin
      if (credit_q == CRED_MAX) ovf_d = 1'b1;
      else                      credit_d = credit_q + CNT_W'(1);
    end
    out_valid_d = send;
    out_data_d  = send ? win_flit : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      credit_q    <= CRED_MAX;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      credit_q    <= credit_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign credit_cnt     = credit_q;
  assign err_credit_ovf = ovf_q;
endmodule

// File: tb/tb_hub_port_arbiter.sv
// Bench for hub_port_arbiter: directed scenarios plus random traffic against a queue-level model.
module tb_hub_port_arbiter;
  localparam logic [1:0] T_S = 2'b11, T_H = 2'b10, T_B = 2'b00, T_T = 2'b01;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [6:0]   req = '0;
  logic [139:0] flit_in = '0;
  logic [6:0]   grant;
  logic [19:0]  out_data;
  logic         out_valid;
  logic         credit_in = 1'b0;
  logic [2:0]   credit_cnt;
  logic         err_credit_ovf;

  hub_port_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .flit_in(flit_in), .grant(grant),
    .out_data(out_data), .out_valid(out_valid), .credit_in(credit_in),
    .credit_cnt(credit_cnt), .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [19:0] q [0:6][$];
  logic [6:0]  obs_grant;

  // Reference model: packet-level state of the output port.
  bit          m_locked;
  int          m_owner, m_ptr, m_cred;
  bit          m_ovf, m_valid;
  logic [19:0] m_data;

  function automatic logic [19:0] mk(input logic [1:0] t, input int i);
    return {t, 3'(i), 15'($urandom)};
  endfunction

  task automatic clear_q();
    for (int i = 0; i < 7; i++) q[i].delete();
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < 7; i++) begin
      req[i] = (q[i].size() != 0);
      flit_in[i*20 +: 20] = (q[i].size() != 0) ? q[i][0] : 20'h0;
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_ptr = 0; m_cred = 4; m_ovf = 0; m_valid = 0; m_data = '0;
  endtask

  function automatic int model_pick();
    if (m_cred == 0) return -1;
    if (m_locked) return (q[m_owner].size() != 0) ? m_owner : -1;
    for (int k = 0; k < 7; k++) if (q[(m_ptr + k) % 7].size() != 0) return (m_ptr + k) % 7;
    return -1;
  endfunction

  // One clock: check the combinational grant, clock, then check registered outputs.
  task automatic cycle(input bit crd);
    int w;
    logic [6:0]  eg;
    logic [19:0] f;
    apply_inputs();
    credit_in = crd;
    #2;
    w  = model_pick();
    eg = (w < 0) ? 7'd0 : (7'd1 << w);
    obs_grant = grant;
    n_chk++;
    if (grant !== eg) $display("FAIL grant c%0d: got %b exp %b", cyc, grant, eg);
    else n_pass++;
    @(posedge clk);
    if (w >= 0) begin
      f = q[w].pop_front();
      if (!m_locked) begin
        m_ptr = (w + 1) % 7;
        if (f[19:18] == T_H) begin m_locked = 1; m_owner = w; end
      end else if (f[19:18] == T_T || f[19:18] == T_S) m_locked = 0;
      m_data = f; m_valid = 1;
    end else m_valid = 0;
    if (w >= 0 && !crd) m_cred--;
    else if (w < 0 && crd) begin
      if (m_cred == 4) m_ovf = 1; else m_cred++;
    end
    #1;
    cyc++;
    n_chk++;
    if (out_valid !== m_valid) $display("FAIL out_valid c%0d: got %b exp %b", cyc, out_valid, m_valid);
    else n_pass++;
    n_chk++;
    if (out_data !== m_data) $display("FAIL out_data c%0d: got %h exp %h", cyc, out_data, m_data);
    else n_pass++;
    n_chk++;
    if (credit_cnt !== 3'(m_cred)) $display("FAIL credit_cnt c%0d: got %0d exp %0d", cyc, credit_cnt, m_cred);
    else n_pass++;
    n_chk++;
    if (err_credit_ovf !== m_ovf) $display("FAIL err_credit_ovf c%0d: got %b exp %b", cyc, err_credit_ovf, m_ovf);
    else n_pass++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    credit_in = 1'b0;
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_vals(input string tag);
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL %s out_valid: got %b exp 0", tag, out_valid); else n_pass++;
    n_chk++;
    if (out_data !== 20'h0) $display("FAIL %s out_data: got %h exp 0", tag, out_data); else n_pass++;
    n_chk++;
    if (credit_cnt !== 3'd4) $display("FAIL %s credit_cnt: got %0d exp 4", tag, credit_cnt); else n_pass++;
    n_chk++;
    if (err_credit_ovf !== 1'b0) $display("FAIL %s err_ovf: got %b exp 0", tag, err_credit_ovf); else n_pass++;
  endtask

  task automatic test_reset();
    clear_q();
    for (int i = 0; i < 7; i++) repeat (3) q[i].push_back(mk(T_S, i));
    do_reset();
    check_reset_vals("reset");
  endtask

`ifndef HUB_ARB_RING_PRIORITY_EN
  task automatic test_rr_order();
    logic [6:0] exp_g [0:5];
    exp_g = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h00, 7'h00};
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0);
      n_chk++;
      if (obs_grant !== exp_g[c]) $display("FAIL rr_order[%0d]: got %b exp %b", c, obs_grant, exp_g[c]);
      else n_pass++;
    end
    n_chk++;
    if (credit_cnt !== 3'd0) $display("FAIL rr_drain credit: got %0d exp 0", credit_cnt); else n_pass++;
  endtask

  task automatic test_packet_lock();
    logic [19:0] h, b, t;
    clear_q();
    do_reset();
    q[0].push_back(mk(T_S, 0));
    cycle(1'b1);
    h = mk(T_H, 3); b = mk(T_B, 3); t = mk(T_T, 3);
    q[3].push_back(h); q[3].push_back(b); q[3].push_back(t);
    q[0].push_back(mk(T_S, 0)); q[0].push_back(mk(T_S, 0));
    cycle(1'b1);
    n_chk++; if (out_data !== h) $display("FAIL lock head: got %h exp %h", out_data, h); else n_pass++;
    cycle(1'b1);
    n_chk++; if (out_data !== b) $display("FAIL lock body: got %h exp %h", out_data, b); else n_pass++;
    cycle(1'b1);
    n_chk++; if (out_data !== t) $display("FAIL lock tail: got %h exp %h", out_data, t); else n_pass++;
    cycle(1'b1);
    n_chk++; if (obs_grant !== 7'h01) $display("FAIL after_tail grant: got %b exp 0000001", obs_grant); else n_pass++;
    q[1].push_back(mk(T_S, 1));
    cycle(1'b1);
    n_chk++; if (obs_grant !== 7'h02) $display("FAIL ptr_after_0 grant: got %b exp 0000010", obs_grant); else n_pass++;
  endtask

  task automatic test_credit_stream();
    clear_q();
    do_reset();
    repeat (12) q[4].push_back(mk(T_S, 4));
    for (int c = 0; c < 10; c++) begin
      cycle(c >= 2);
      if (c >= 1) begin
        n_chk++;
        if (credit_cnt !== 3'd2) $display("FAIL stream credit[%0d]: got %0d exp 2", c, credit_cnt);
        else n_pass++;
      end
    end
  endtask

  task automatic test_credit_ovf();
    clear_q();
    do_reset();
    cycle(1'b1);
    n_chk++; if (err_credit_ovf !== 1'b1) $display("FAIL ovf set: got %b exp 1", err_credit_ovf); else n_pass++;
    n_chk++; if (credit_cnt !== 3'd4) $display("FAIL ovf sat: got %0d exp 4", credit_cnt); else n_pass++;
    repeat (3) cycle(1'b0);
    q[2].push_back(mk(T_S, 2));
    cycle(1'b0);
    n_chk++; if (err_credit_ovf !== 1'b1) $display("FAIL ovf sticky: got %b exp 1", err_credit_ovf); else n_pass++;
    clear_q();
    do_reset();
    check_reset_vals("ovf_clear");
  endtask

  task automatic test_credit_zero();
    clear_q();
    do_reset();
    q[3].push_back(mk(T_H, 3));
    repeat (4) q[3].push_back(mk(T_B, 3));
    q[3].push_back(mk(T_T, 3));
    repeat (4) cycle(1'b0);
    q[0].push_back(mk(T_S, 0));
    cycle(1'b0);
    n_chk++; if (obs_grant !== 7'h00) $display("FAIL zero_credit grant: got %b exp 0", obs_grant); else n_pass++;
    cycle(1'b1);
    n_chk++; if (obs_grant !== 7'h00) $display("FAIL credit_arrive grant: got %b exp 0", obs_grant); else n_pass++;
    cycle(1'b0);
    n_chk++; if (obs_grant !== 7'h08) $display("FAIL lock_held grant: got %b exp 0001000", obs_grant); else n_pass++;
    repeat (6) cycle(1'b1);
  endtask

  task automatic test_reset_mid_packet();
    clear_q();
    do_reset();
    q[5].push_back(mk(T_H, 5)); q[5].push_back(mk(T_B, 5)); q[5].push_back(mk(T_T, 5));
    cycle(1'b0);
    clear_q();
    q[2].push_back(mk(T_S, 2));
    rst = 1'b1;
    apply_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL midpkt out_valid: got %b exp 0", out_valid); else n_pass++;
    n_chk++; if (credit_cnt !== 3'd4) $display("FAIL midpkt credit: got %0d exp 4", credit_cnt); else n_pass++;
    cycle(1'b0);
    n_chk++; if (obs_grant !== 7'h04) $display("FAIL midpkt grant: got %b exp 0000100", obs_grant); else n_pass++;
  endtask

  task automatic push_pkt(input int i);
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) q[i].push_back(mk(T_S, i));
    else if (r < 9) begin
      q[i].push_back(mk(T_H, i));
      repeat ($urandom_range(0, 3)) q[i].push_back(mk(T_B, i));
      q[i].push_back(mk(T_T, i));
    end else q[i].push_back(mk(2'($urandom), i));
  endtask

  task automatic test_random();
    clear_q();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 7; i++)
        if ($urandom_range(0, 7) == 0 && q[i].size() < 8) push_pkt(i);
      cycle($urandom_range(0, 2) != 0);
    end
  endtask
`else
  task automatic test_ring_priority();
    clear_q();
    do_reset();
    for (int i = 0; i < 7; i++) flit_in[i*20 +: 20] = {T_S, 18'(i)};
    req = 7'b0010001;
    credit_in = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      #2;
      n_chk++;
      if (grant !== ((c == 16) ? 7'h10 : 7'h01))
        $display("FAIL ring_prio[%0d]: got %b exp %b", c, grant, (c == 16) ? 7'h10 : 7'h01);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    credit_in = 1'b0;
    req = '0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifndef HUB_ARB_RING_PRIORITY_EN
    test_rr_order();
    test_packet_lock();
    test_credit_stream();
    test_credit_ovf();
    test_credit_zero();
    test_reset_mid_packet();
    test_random();
`else
    test_ring_priority();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/hub_port_arbiter.md
Name: hub_port_arbiter

Overview:
- Output-port scheduler for the 7-port cluster hub router. One instance per output port.
- Shares a single 20-bit output link among 7 input requesters: ring CW, ring CCW, superhub down-link and leaf0..leaf3.
- Uses round-robin arbitration with wormhole packet locking and credit-based flow control toward the downstream receiver.
- The output stage is registered. Each granted flit pops its input buffer in the same cycle.

Parameters:
- NUM_IN, 7, number of requesting inputs. Index 0 = ring CW, 1 = ring CCW, 2 = superhub, 3..6 = leaf0..leaf3.
- FLIT_W, 20, flit width.
- CREDITS, 4, downstream buffer depth. Also the credit counter reset value.
- CNT_W, 3, credit counter width. Must hold CREDITS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req  in  NUM_IN  per-input flit-available, level
- flit_in  in  NUM_IN*FLIT_W  flattened input flits; input i occupies bits [i*FLIT_W +: FLIT_W]
- grant  out  NUM_IN  one-hot, combinational pop strobe to the granted input buffer
- out_data  out  FLIT_W  registered output flit
- out_valid  out  1  registered, one-cycle pulse per flit
- credit_in  in  1  one-cycle pulse = one downstream slot freed
- credit_cnt  out  CNT_W  current credits
- err_credit_ovf  out  1  sticky, credit returned while counter == CREDITS

Behaviour:
- Clock and reset: clk is the single clock. rst is synchronous and active-high.
- Reset values: out_data=0, out_valid=0, credit_cnt=CREDITS, err_credit_ovf=0, rr pointer=0, FSM=IDLE, lock owner=0.
- Flit type field is flit[19:18]:
  - 2'b11 single
  - 2'b10 head
  - 2'b00 body
  - 2'b01 tail
- can_send = (credit_cnt != 0).
- FSM IDLE:
  - If can_send and req != 0, grant the first requester at or after the rr pointer, searching upward with wrap (6 -> 0).
  - If the granted flit is a head, latch the owner and go to LOCKED.
  - If the granted flit is single (or body/tail, which is a protocol error tolerated as single), stay in IDLE.
  - On every IDLE grant, set rr pointer = winner+1, wrapping 6 -> 0.
- FSM LOCKED:
  - Only the owner may be granted. Grant it when req[owner] and can_send are both high. Other requests wait.
  - A granted tail returns the FSM to IDLE. A granted single also returns to IDLE (error tolerance).
  - The rr pointer does not change while LOCKED.
- grant:
  - Combinational, at most one bit high.
  - Zero when can_send=0.
  - A granted flit appears on out_data with out_valid=1 on the next clock: latency 1 cycle.
- Credits:
  - A send decrements the counter. credit_in increments it.
  - A send and credit_in in the same cycle leave the count unchanged.
  - credit_in at CREDITS with no send: counter saturates and err_credit_ovf is set. Only rst clears it.
- Back-to-back: one flit per cycle is sustained while credits remain.
- At credit_cnt=0:
  - grant=0. The FSM holds its state and any lock.
  - A credit_in that arrives while credit_cnt=0 enables a grant in the following cycle.
- Reset mid-packet: drops the lock and returns the FSM to IDLE. The upstream sources are reset by the same rst.
- out_data holds its last value when out_valid=0.

Optional Feature:
- Macro: HUB_ARB_RING_PRIORITY_EN.
- With the macro defined, IDLE arbitration changes as follows:
  - Inputs 0 and 1 (ring) take strict priority over inputs 2..6.
  - Round-robin runs within each class; the classes keep separate pointers.
  - A 4-bit starvation counter increments each IDLE cycle in which a local request (2..6) loses to a ring grant.
  - When the counter reaches 15, the next IDLE grant goes to the local class. The counter clears on any local grant.
- Without the macro: flat 7-way round-robin as described above.

Decomposition:
- Shared package hub_noc_pkg:
  - FLIT_W, NUM_IN.
  - Flit type constants FLIT_SINGLE/HEAD/BODY/TAIL.
  - Port index constants P_RING_CW=0, P_RING_CCW=1, P_SH=2, P_LEAF0..P_LEAF3=3..6.
  - FSM state encoding ARB_IDLE/ARB_LOCKED.
- Sub-module: rr_pick7, a combinational round-robin picker (req, pointer -> one-hot, index). It is instantiated once, or twice under the optional feature.

Test Plan:
- Reset with all req=1 and single flits -> after reset, grants in order 0,1,2,3 on successive cycles. credit_cnt reaches 0 after 4 sends and grant=0 from then on.
- Input 3 sends head/body/tail while req[0] is held high -> out_valid carries input 3's three flits consecutively. Input 0 is granted in the cycle after the tail and the pointer becomes 1.
- CREDITS=4 stream with credit_in pulsed every cycle from cycle 2 -> credit_cnt stays at 2. A send and a credit in the same cycle keep the count.
- credit_in pulsed at credit_cnt=4 with no traffic -> credit_cnt remains 4 and err_credit_ovf=1 until rst.
- rst asserted while LOCKED on input 5 after its head -> the next cycle shows IDLE, out_valid=0, credit_cnt=4. A request from input 2 is granted immediately.
- With HUB_ARB_RING_PRIORITY_EN, req[0] held high continuously and req[4] high -> input 4 is granted on the 16th arbitration cycle and input 0 on all other cycles.
